i2c_master_ctrl: RTL and testbench
==================================

// Module: i2c_master_ctrl
// PURPOSE
//  Single-byte I2C bus master: one transaction per enable pulse (START, 7-bit addr + R/W,
//  ACK, one data byte, ACK/NACK, STOP). Sits between a local register/command interface
//  and the board-level SDA/SCL wires; the peer is an I2C slave on the same two nets.
// PARAMETERS
//  DIV      4   clk cycles per SCL bit period (even, >=4); SCL low DIV/2, high DIV/2
// PORTS
//  clk       in     1  system clock, all logic on rising edge
//  rst       in     1  asynchronous, active-high reset
//  addr      in     7  target slave address, latched on accept
//  data_in   in     8  write byte, latched on accept
//  enable    in     1  start request, level-sampled each clk while idle
//  rw        in     1  0=write, 1=read; latched on accept
//  data_out  out    8  last byte read from slave
//  ready     out    1  1 = idle, can accept a request
//  i2c_sda   inout  1  serial data; driven 0/1 on master bits, 'z on slave bits
//  i2c_scl   out    1  serial clock, push-pull, idles high
// BEHAVIOUR
//  Reset: state IDLE, ready=1, data_out=8'h00, i2c_scl=1, i2c_sda=1 (driven), divider=0.
//  Accept: in IDLE, enable=1 on a clk edge latches addr/data_in/rw; ready drops next cycle.
//   enable while busy is ignored (no queue). Accept and reset coincident: reset wins.
//  Bit timing: free-running divider, bit = DIV clks; SDA changes only while SCL low,
//   except START (SDA 1->0, SCL high) and STOP (SDA 0->1, SCL high). Slave bits sampled
//   on the clk where SCL goes high.
//  States: IDLE -> START -> ADDR(8 bits: addr[6:0] MSB first, then rw)
//   -> ADDR_ACK (SDA released; sample 0=ACK, anything else incl. 'z/1 = NACK)
//   -> ACK & rw=0: WR_DATA(8 bits data_in MSB first) -> WR_ACK -> STOP
//   -> ACK & rw=1: RD_DATA(8 bits, SDA released, shift MSB first) -> MST_NACK
//      (master drives SDA=1) -> STOP
//   -> NACK: STOP (no data phase). WR_ACK NACK also -> STOP.
//  STOP -> IDLE; ready=1 on the clk after STOP's SDA rise; min 1 bit-period bus-free.
//  data_out updated once, at end of RD_DATA byte; unchanged by writes/aborts.
//  Frame length: START 1 + 8 + 1 + 8 + 1 + STOP 1 = 20 bit periods (80 clks at DIV=4).
//  Reset mid-transaction: immediate abort, SCL/SDA high, IDLE; no STOP generated.
//  SCL held high and SDA driven 1 whenever idle.
// CONFIGURATION
//  I2C_ACK_ERR_EN defined: extra output port ack_err (1 bit, reset 0), set on any NACK
//   at ADDR_ACK or WR_ACK, held until next accepted request (cleared on accept).
//  Not defined: port absent; NACK still aborts to STOP silently.
// TESTING
//  Bench must pull up SDA and model a slave that ACKs address 7'h2A only.
//  Write: addr=7'h2A, data_in=8'hAA, rw=0, enable 5 clks -> SDA bytes 8'h54 then 8'hAA,
//   two ACKs, STOP; ready low 80 clks then high; data_out stays 8'h00.
//  Read: addr=7'h2A, rw=1, slave returns 8'hA5 -> addr byte 8'h55, master NACK, STOP;
//   data_out=8'hA5 when ready rises.
//  NACK: addr=7'h11 -> ADDR_ACK samples 1 -> STOP after 10 bits; no data clocked;
//   ack_err=1 when I2C_ACK_ERR_EN.
//  Busy: enable re-asserted with data_in=8'h0F mid-write -> ignored, first frame intact.
//  Reset mid-frame: rst during ADDR bit 4 -> SCL=1, SDA=1, ready=1, data_out retains
//   reset value; next request completes normally.

Source files
------------

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl: single-byte I2C master. One frame per accepted request:
// START, address + R/W, ACK, one data byte (write or read), ACK/NACK, STOP.
// Each bit lasts DIV clocks. SCL is low for the first half of the bit and high for the second.
// Master-driven SDA changes on phase 1, while SCL is low.
// Slave-driven SDA is sampled on the clock where SCL rises.
// Optional feature: define I2C_ACK_ERR_EN to add the ack_err output.
module i2c_master_ctrl #(
    parameter int DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] addr,
    input  logic [7:0] data_in,
    input  logic       enable,
    input  logic       rw,
    output logic [7:0] data_out,
    output logic       ready,
    inout  wire        i2c_sda,
    output logic       i2c_scl
`ifdef I2C_ACK_ERR_EN
    ,
    output logic       ack_err
`endif
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ADDR_ACK,
        S_WR_DATA,
        S_WR_ACK,
        S_RD_DATA,
        S_MST_NACK,
        S_STOP
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            bit_end;
    logic [2:0]      bit_q;
    logic [7:0]      shift_q;
    logic [7:0]      wdata_q;
    logic            rw_q;
    logic            ack_q;
    logic [7:0]      rx_q;
    logic [7:0]      data_out_q;
    logic            ready_q;
    logic            scl_q;
    logic            sda_q;
    logic            sda_oe_q;
`ifdef I2C_ACK_ERR_EN
    logic            ack_err_q;
`endif

    // Bit-period divider: next phase and end-of-bit flag.
    // NOTE: every signal assigned in a combinational block gets a value on every path, so no latch is inferred.
    always_comb begin
        bit_end = (cnt_q == CW'(DIV - 1));
        cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    end

    // Transaction FSM with registered bus and handshake outputs.
    // NOTE: state is updated with non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            wdata_q    <= '0;
            rw_q       <= 1'b0;
            ack_q      <= 1'b0;
            rx_q       <= '0;
            data_out_q <= '0;
            ready_q    <= 1'b1;
            scl_q      <= 1'b1;
            sda_q      <= 1'b1;
            sda_oe_q   <= 1'b1;
`ifdef I2C_ACK_ERR_EN
            ack_err_q  <= 1'b0;
`endif
        end else if (state_q == S_IDLE) begin
            // Bus is idle: SCL high, SDA driven high. A request starts the divider from phase 0.
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            sda_oe_q <= 1'b1;
            cnt_q    <= '0;
            if (enable) begin
                state_q   <= S_START;
                ready_q   <= 1'b0;
                shift_q   <= {addr, rw};
                wdata_q   <= data_in;
                rw_q      <= rw;
                bit_q     <= '0;
`ifdef I2C_ACK_ERR_EN
                ack_err_q <= 1'b0;
`endif
            end
        end else begin
            cnt_q <= cnt_d;
            if (bit_end) begin
                // Every bit after START opens with SCL low. STOP overrides this when it returns to idle.
                scl_q <= 1'b0;
                case (state_q)
                    S_START: begin
                        state_q <= S_ADDR;
                        bit_q   <= '0;
                    end
                    S_ADDR: begin
                        shift_q <= {shift_q[6:0], 1'b0};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= S_ADDR_ACK;
                    end
                    S_ADDR_ACK: begin
                        if (ack_q) begin
                            state_q <= rw_q ? S_RD_DATA : S_WR_DATA;
                            shift_q <= wdata_q;
                            bit_q   <= '0;
                        end else begin
                            state_q <= S_STOP;
`ifdef I2C_ACK_ERR_EN
                            ack_err_q <= 1'b1;
`endif
                        end
                    end
                    S_WR_DATA: begin
                        shift_q <= {shift_q[6:0], 1'b0};
                        bit_q   <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= S_WR_ACK;
                    end
                    S_WR_ACK: begin
                        state_q <= S_STOP;
`ifdef I2C_ACK_ERR_EN
                        if (!ack_q) ack_err_q <= 1'b1;
`endif
                    end
                    S_RD_DATA: begin
                        bit_q <= bit_q + 1'b1;
                        if (bit_q == 3'd7) state_q <= S_MST_NACK;
                    end
                    S_MST_NACK: state_q <= S_STOP;
                    S_STOP: begin
                        state_q <= S_IDLE;
                        ready_q <= 1'b1;
                        scl_q   <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end else begin
                // Phase 1 (SCL low): put the master's bit on SDA, or release SDA for a slave bit.
                if (cnt_d == CW'(1)) begin
                    case (state_q)
                        S_ADDR, S_WR_DATA: begin
                            sda_q    <= shift_q[7];
                            sda_oe_q <= 1'b1;
                        end
                        S_ADDR_ACK, S_WR_ACK, S_RD_DATA: sda_oe_q <= 1'b0;
                        S_MST_NACK: begin
                            sda_q    <= 1'b1;
                            sda_oe_q <= 1'b1;
                        end
                        S_STOP: begin
                            sda_q    <= 1'b0;
                            sda_oe_q <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                // Half period: START pulls SDA low under a high SCL; every other bit raises SCL and samples.
                if (cnt_d == CW'(DIV / 2)) begin
                    if (state_q == S_START) begin
                        sda_q <= 1'b0;
                    end else begin
                        scl_q <= 1'b1;
                        case (state_q)
                            S_ADDR_ACK, S_WR_ACK: ack_q <= ~i2c_sda;
                            S_RD_DATA: begin
                                rx_q <= {rx_q[6:0], i2c_sda};
                                if (bit_q == 3'd7) data_out_q <= {rx_q[6:0], i2c_sda};
                            end
                            default: ;
                        endcase
                    end
                end
                // STOP: SDA rises one clock after SCL went high.
                if (state_q == S_STOP && cnt_d == CW'(DIV / 2 + 1)) sda_q <= 1'b1;
            end
        end
    end

    assign i2c_sda  = sda_oe_q ? sda_q : 1'bz;
    assign i2c_scl  = scl_q;
    assign ready    = ready_q;
    assign data_out = data_out_q;
`ifdef I2C_ACK_ERR_EN
    assign ack_err  = ack_err_q;
`endif

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl.
// It runs directed frames and random frames against a frame-level reference model.
// A bus slave model ACKs address 7'h2A only.
module tb_i2c_master_ctrl;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] addr;
    logic [7:0] data_in;
    logic       enable;
    logic       rw;
    wire  [7:0] data_out;
    wire        ready;
    wire        sda_w;
    wire        scl_w;
`ifdef I2C_ACK_ERR_EN
    wire        ack_err;
    logic       exp_err = 1'b0;
`endif

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] exp_dout = 8'h00;
    logic [7:0] slv_byte = 8'h00;
    logic       slv_low  = 1'b0;

    logic       q_bits[$];
    logic       in_frame = 1'b0;
    int         n_start  = 0;
    int         n_stop   = 0;
    logic       sda_prev = 1'b1;
    logic       scl_prev = 1'b1;

    i2c_master_ctrl #(.DIV(DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .addr     (addr),
        .data_in  (data_in),
        .enable   (enable),
        .rw       (rw),
        .data_out (data_out),
        .ready    (ready),
        .i2c_sda  (sda_w),
        .i2c_scl  (scl_w)
`ifdef I2C_ACK_ERR_EN
        ,
        .ack_err  (ack_err)
`endif
    );

    assign sda_w = slv_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Bus monitor: detects START and STOP, and records SDA at every SCL rise inside a frame.
    always @(sda_w or scl_w) begin
        if (scl_w == 1'b1 && scl_prev == 1'b1 && sda_prev == 1'b1 && sda_w == 1'b0) begin
            q_bits.delete();
            in_frame = 1'b1;
            n_start++;
        end else if (scl_w == 1'b1 && scl_prev == 1'b1 && sda_prev == 1'b0 && sda_w == 1'b1 && in_frame) begin
            in_frame = 1'b0;
            n_stop++;
        end else if (scl_prev == 1'b0 && scl_w == 1'b1 && in_frame) begin
            q_bits.push_back(sda_w);
        end
        sda_prev = sda_w;
        scl_prev = scl_w;
    end

    // Slave behaviour for SCL pulse k (0-based, counted from START).
    function automatic logic slave_low(input int k);
        logic [7:0] ab;
        if (k < 8) return 1'b0;
        for (int i = 0; i < 8; i++) ab[7-i] = q_bits[i];
        if (ab[7:1] != 7'h2A) return 1'b0;
        if (k == 8) return 1'b1;
        if (ab[0]) begin
            if (k >= 9 && k <= 16) return !slv_byte[16-k];
            return 1'b0;
        end
        return (k == 17);
    endfunction

    // The slave lets go of SDA as SCL falls. It drives its next bit after the master has released SDA.
    always @(negedge scl_w) begin
        slv_low = 1'b0;
        if (in_frame) begin
            @(posedge clk);
            #1;
            slv_low = slave_low(q_bits.size());
        end
    end

    task automatic run_txn(input logic [6:0] a, input logic [7:0] d, input logic r,
                           input logic [7:0] sb, input int en_cycles, input bit poke);
        logic        exp_q[$];
        logic [7:0]  ab;
        logic        acked;
        int          low_cnt;
        int          k;
        int          stop_before;
        logic [31:0] gw;
        logic [31:0] ew;
        ab    = {a, r};
        acked = (a == 7'h2A);
        for (int i = 7; i >= 0; i--) exp_q.push_back(ab[i]);
        exp_q.push_back(!acked);
        if (acked) begin
            for (int i = 7; i >= 0; i--) exp_q.push_back(r ? sb[i] : d[i]);
            exp_q.push_back(r);
            if (r) exp_dout = sb;
        end
        exp_q.push_back(1'b0);
`ifdef I2C_ACK_ERR_EN
        exp_err = !acked;
`endif
        slv_byte    = sb;
        stop_before = n_stop;
        @(negedge clk);
        addr = a; data_in = d; rw = r; enable = 1'b1;
        low_cnt = 0;
        k = 0;
        while (k < 400) begin
            @(negedge clk);
            k++;
            if (k == en_cycles) enable = 1'b0;
            if (poke && k == 30) begin
                data_in = 8'h0F; addr = 7'h11; rw = ~r; enable = 1'b1;
            end
            if (poke && k == 34) enable = 1'b0;
            if (ready) break;
            low_cnt++;
        end
        enable = 1'b0;
        check("ready_timeout", 32'(k >= 400), 32'd0);
        check("ready_low_clks", 32'(low_cnt), 32'(DIV * (acked ? 20 : 11)));
        check("stop_seen", 32'(n_stop - stop_before), 32'd1);
        gw = '0;
        ew = '0;
        foreach (q_bits[i]) gw = {gw[30:0], q_bits[i]};
        foreach (exp_q[i]) ew = {ew[30:0], exp_q[i]};
        check("frame_len", 32'(q_bits.size()), 32'(exp_q.size()));
        check("frame_bits", gw, ew);
        check("data_out", 32'(data_out), 32'(exp_dout));
`ifdef I2C_ACK_ERR_EN
        check("ack_err", 32'(ack_err), 32'(exp_err));
`endif
    endtask

    task automatic run_reset_abort();
        int k;
        int start_before;
        start_before = n_start;
        slv_byte = 8'h3C;
        @(negedge clk);
        addr = 7'h2A; data_in = 8'h99; rw = 1'b0; enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        k = 0;
        while ((n_start == start_before || q_bits.size() < 4) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_wait_timeout", 32'(k >= 200), 32'd0);
        repeat (DIV / 2 + 1) @(negedge clk);
        rst = 1'b1;
        exp_dout = 8'h00;
`ifdef I2C_ACK_ERR_EN
        exp_err = 1'b0;
`endif
        @(negedge clk);
        check("abort_scl", 32'(scl_w), 32'd1);
        check("abort_sda", 32'(sda_w), 32'd1);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_data_out", 32'(data_out), 32'(exp_dout));
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("post_abort_ready", 32'(ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] a;
        rst = 1'b1; enable = 1'b0; addr = '0; data_in = '0; rw = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_data_out", 32'(data_out), 32'h00);
        check("rst_scl", 32'(scl_w), 32'd1);
        check("rst_sda", 32'(sda_w), 32'd1);
`ifdef I2C_ACK_ERR_EN
        check("rst_ack_err", 32'(ack_err), 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_txn(7'h2A, 8'hAA, 1'b0, 8'h00, 5, 1'b0);
        run_txn(7'h2A, 8'h00, 1'b1, 8'hA5, 1, 1'b0);
        run_txn(7'h11, 8'h77, 1'b0, 8'h00, 2, 1'b0);
        run_txn(7'h2A, 8'hAA, 1'b0, 8'h00, 5, 1'b1);

        for (int i = 0; i < 16; i++) begin
            a = ($urandom_range(0, 1) == 1) ? 7'h2A : 7'($urandom);
            run_txn(a, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                    int'($urandom_range(1, 5)), 1'b0);
        end

        run_reset_abort();
        run_txn(7'h2A, 8'h5A, 1'b1, 8'hC3, 3, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
